// File: rtl/tdm_demux_if.sv
// TDM link bundle: one slot word per valid cycle, with a start-of-frame marker on slot 0.
interface tdm_demux_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_sof;
    logic [W-1:0] in_data;

    // Upstream mux drives the link
    modport master (
        output in_valid,
        output in_sof,
        output in_data
    );

    // Demux receives the link
    modport slave (
        input in_valid,
        input in_sof,
        input in_data
    );
endinterface

// File: rtl/tdm_demux.sv
// TDM demultiplexer: tracks slot position from SOF, assembles a frame in shadow
// registers and publishes all N_CH channel words at once when the last slot lands.
// Early SOF inside a frame is a framing error; the partial frame is dropped.
module tdm_demux #(
    parameter int N_CH      = 4,
    parameter int W         = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tdm_demux_if.slave           link,
    output logic [N_CH*W-1:0]    ch_data,
    output logic                 frame_valid,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 locked
);

    localparam int SW = $clog2(N_CH);
    localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t                 state, state_next;
    logic [SW-1:0]          slot, slot_next;
    logic [N_CH-1:0][W-1:0] shadow, shadow_next;
    logic [N_CH*W-1:0]      ch_data_next;
    logic                   frame_valid_next;
    logic                   frame_err_next;
    logic [ERR_CNT_W-1:0]   err_cnt_next;

    // Register all state and outputs; reset discards any partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            slot        <= '0;
            shadow      <= '0;
            ch_data     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_cnt     <= '0;
        end else begin
            state       <= state_next;
            slot        <= slot_next;
            shadow      <= shadow_next;
            ch_data     <= ch_data_next;
            frame_valid <= frame_valid_next;
            frame_err   <= frame_err_next;
            err_cnt     <= err_cnt_next;
        end
    end

    // Next-state and datapath: steer words into shadow slots, publish on last slot
    always_comb begin
        state_next       = state;
        slot_next        = slot;
        shadow_next      = shadow;
        ch_data_next     = ch_data;
        frame_valid_next = 1'b0;
        frame_err_next   = 1'b0;
        err_cnt_next     = err_cnt;

        case (state)
            HUNT: begin
                if (link.in_valid && link.in_sof) begin
                    shadow_next[0] = link.in_data;
                    slot_next      = SW'(1);
                    state_next     = RECV;
                end
            end
            RECV: begin
                if (link.in_valid) begin
                    if (link.in_sof) begin
                        frame_err_next = 1'b1;
                        if (err_cnt != ERR_MAX) begin
                            err_cnt_next = err_cnt + ERR_CNT_W'(1);
                        end
                        shadow_next[0] = link.in_data;
                        slot_next      = SW'(1);
                    end else if (slot == LAST_SLOT) begin
                        shadow_next[LAST_SLOT] = link.in_data;
                        ch_data_next           = shadow_next;
                        frame_valid_next       = 1'b1;
                        slot_next              = '0;
                        state_next             = HUNT;
                    end else begin
                        shadow_next[slot] = link.in_data;
                        slot_next         = slot + SW'(1);
                    end
                end
            end
            default: begin
                state_next = HUNT;
                slot_next  = '0;
            end
        endcase
    end

    // Locked simply mirrors the registered state
    assign locked = (state == RECV);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed testbench for tdm_demux (N_CH=4, W=8, ERR_CNT_W=8).
module tb_tdm_demux;

    logic        clk;
    logic        rst_n;
    logic [31:0] ch_data;
    logic        frame_valid;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic        locked;

    int vectors;
    int miscompares;

    tdm_demux_if #(.W(8)) link ();

    tdm_demux #(
        .N_CH      (4),
        .W         (8),
        .ERR_CNT_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .link        (link),
        .ch_data     (ch_data),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .err_cnt     (err_cnt),
        .locked      (locked)
    );

    // 10 ns free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one link cycle, then wait until just after the capturing edge
    task automatic applyStimulus(input logic v, input logic s, input logic [7:0] d);
        link.in_valid = v;
        link.in_sof   = s;
        link.in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all outputs at once
    task automatic checkAll(input string tag, input logic fv, input logic fe,
                            input logic [31:0] cd, input logic [7:0] ec, input logic lk);
        checkOutput({tag, ".frame_valid"}, 64'(frame_valid), 64'(fv));
        checkOutput({tag, ".frame_err"},   64'(frame_err),   64'(fe));
        checkOutput({tag, ".ch_data"},     64'(ch_data),     64'(cd));
        checkOutput({tag, ".err_cnt"},     64'(err_cnt),     64'(ec));
        checkOutput({tag, ".locked"},      64'(locked),      64'(lk));
    endtask

    logic [7:0] gapWords [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

    // Directed sequence
    initial begin
        vectors     = 0;
        miscompares = 0;
        link.in_valid = 1'b0;
        link.in_sof   = 1'b0;
        link.in_data  = 8'h00;
        rst_n = 1'b0;
        #22;
        checkAll("reset", 1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain frame on consecutive cycles
        applyStimulus(1'b1, 1'b1, 8'hA0);
        checkAll("t1.sof", 1'b0, 1'b0, 32'h0, 8'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'hB1);
        applyStimulus(1'b1, 1'b0, 8'hC2);
        checkAll("t1.mid", 1'b0, 1'b0, 32'h0, 8'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'hD3);
        checkAll("t1.done", 1'b1, 1'b0, 32'hD3C2B1A0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkAll("t1.after", 1'b0, 1'b0, 32'hD3C2B1A0, 8'd0, 1'b0);

        // Same frame with two idle cycles between words
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, (i == 0), gapWords[i]);
            if (i < 3) begin
                checkAll("t2.word", 1'b0, 1'b0, 32'hD3C2B1A0, 8'd0, 1'b1);
                applyStimulus(1'b0, 1'b0, 8'hFF);
                applyStimulus(1'b0, 1'b1, 8'hEE);
                checkAll("t2.gap", 1'b0, 1'b0, 32'hD3C2B1A0, 8'd0, 1'b1);
            end
        end
        checkAll("t2.done", 1'b1, 1'b0, 32'hD3C2B1A0, 8'd0, 1'b0);

        // Early SOF restarts the frame and flags an error
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h11);
        applyStimulus(1'b1, 1'b0, 8'h22);
        applyStimulus(1'b1, 1'b1, 8'h33);
        checkAll("t3.err", 1'b0, 1'b1, 32'hD3C2B1A0, 8'd1, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h44);
        checkAll("t3.errpulse", 1'b0, 1'b0, 32'hD3C2B1A0, 8'd1, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h55);
        applyStimulus(1'b1, 1'b0, 8'h66);
        checkAll("t3.done", 1'b1, 1'b0, 32'h66554433, 8'd1, 1'b0);

        // Back-to-back frames, no bubble
        applyStimulus(1'b1, 1'b1, 8'h10);
        applyStimulus(1'b1, 1'b0, 8'h11);
        applyStimulus(1'b1, 1'b0, 8'h12);
        applyStimulus(1'b1, 1'b0, 8'h13);
        checkAll("t5.first", 1'b1, 1'b0, 32'h13121110, 8'd1, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h20);
        checkAll("t5.sof2", 1'b0, 1'b0, 32'h13121110, 8'd1, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h21);
        applyStimulus(1'b1, 1'b0, 8'h22);
        applyStimulus(1'b1, 1'b0, 8'h23);
        checkAll("t5.second", 1'b1, 1'b0, 32'h23222120, 8'd1, 1'b0);

        // Asynchronous reset in the middle of a frame
        applyStimulus(1'b1, 1'b1, 8'h01);
        applyStimulus(1'b1, 1'b0, 8'h02);
        link.in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        checkAll("t6.async", 1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h03);
        checkAll("t6.nopulse", 1'b0, 1'b0, 32'h0, 8'd0, 1'b0);

        // Words without SOF are dropped in HUNT, then a valid frame
        applyStimulus(1'b1, 1'b0, 8'h77);
        applyStimulus(1'b1, 1'b0, 8'h88);
        checkAll("t4.drop", 1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h01);
        applyStimulus(1'b1, 1'b0, 8'h02);
        applyStimulus(1'b1, 1'b0, 8'h03);
        applyStimulus(1'b1, 1'b0, 8'h04);
        checkAll("t4.done", 1'b1, 1'b0, 32'h04030201, 8'd0, 1'b0);

        // Saturate the error counter: one SOF to lock, then 260 early SOFs
        applyStimulus(1'b1, 1'b1, 8'h5A);
        for (int i = 0; i < 255; i++) begin
            applyStimulus(1'b1, 1'b1, 8'h5A);
        end
        checkAll("t6.sat255", 1'b0, 1'b1, 32'h04030201, 8'd255, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 8'h5A);
        end
        checkAll("t6.sathold", 1'b0, 1'b1, 32'h04030201, 8'd255, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkAll("t6.idle", 1'b0, 1'b0, 32'h04030201, 8'd255, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receiving end of a time-division multiplexed word link. Upstream, a mux driven by a rotating select places one channel word per slot onto a shared bus.
- This block tracks slot position from a start-of-frame marker and steers each word into its own channel register.
- It publishes a complete, coherent frame of N_CH parallel words and flags framing errors.
- It sits between the TDM link and per-channel consumers.

Parameters:
- N_CH, 4, number of channels (slots) per frame; legal range 2..16.
- W, 8, data width of one channel word.
- ERR_CNT_W, 8, width of the saturating framing-error counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_sof are meaningful this cycle.
- in_sof  input  1  start of frame; the word carries slot 0. Ignored when in_valid=0.
- in_data  input  W  slot word.
- ch_data  output  N_CH*W  frame output; channel k occupies bits [k*W +: W].
- frame_valid  output  1  one-cycle pulse; ch_data was just updated with a complete frame.
- frame_err  output  1  one-cycle pulse; a framing error was detected.
- err_cnt  output  ERR_CNT_W  saturating count of frame_err pulses.
- locked  output  1  high while in RECV state.

Behaviour:
- Reset (rst_n=0, asynchronous): state=HUNT, slot counter=0, shadow registers=0, ch_data=0, frame_valid=0, frame_err=0, err_cnt=0, locked=0. Any partial frame is discarded.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Slot counter width is $clog2(N_CH).
- Shadow registers hold the frame being assembled. ch_data changes only when a frame completes.

State HUNT:
- in_valid & in_sof: write in_data to shadow[0], slot=1, go to RECV.
- in_valid & !in_sof: word dropped silently; no error is flagged.
- !in_valid: hold.

State RECV (locked=1):
- in_valid & !in_sof & slot<N_CH-1: write shadow[slot], slot++.
- in_valid & !in_sof & slot==N_CH-1 (last slot): on this edge, ch_data <= shadow[0..N_CH-2] concatenated with in_data in slot N_CH-1, and frame_valid=1 for the next cycle. slot=0, go to HUNT.
- Latency: frame_valid and the new ch_data are visible one clock after the cycle presenting the last word.
- in_valid & in_sof (early SOF, frame incomplete): frame_err=1 for one cycle and err_cnt++. The partial frame is discarded and ch_data is untouched. The word is taken as slot 0 of a new frame: shadow[0]=in_data, slot=1, stay in RECV.
- !in_valid: hold. Gaps inside a frame are legal and have no timeout.

Other rules:
- The next frame must begin with in_sof. A word without SOF after a completed frame is dropped in HUNT.
- After frame completion, in_valid & in_sof on the very next cycle is accepted normally, so back-to-back frames run with no bubble.
- frame_valid and frame_err never assert in the same cycle.
- err_cnt saturates at 2^ERR_CNT_W-1 and does not wrap.
- Reset mid-frame: everything returns to reset values immediately. No frame_valid is produced for the interrupted frame.

Test Plan:
1. Reset, then a frame with N_CH=4, W=8: words A0(sof),B1,C2,D3 on consecutive cycles -> one cycle later ch_data=0xD3C2B1A0, frame_valid=1 for exactly 1 cycle; locked falls to 0.
2. Same frame with in_valid=0 gaps of 2 cycles between words -> identical ch_data=0xD3C2B1A0; frame_valid only after D3; no frame_err.
3. Words 11(sof),22 then 33(sof),44,55,66 -> frame_err pulse on the cycle after 33; err_cnt=1; ch_data=0x66554433 with one frame_valid; ch_data never shows 0x..2211.
4. Without SOF, send 77,88 after reset, then a valid frame 01(sof),02,03,04 -> 77/88 dropped, no error; ch_data=0x04030201.
5. Two back-to-back frames (no idle cycle) 10..13 then 20..23 -> two frame_valid pulses 4 cycles apart; final ch_data=0x23222120.
6. Drive rst_n low after 2 words of a frame -> outputs clear asynchronously (before the next clk edge). After release, a fresh frame is received correctly. Separately, force 260 early-SOF errors -> err_cnt holds at 255.
